// File: rtl/tick_pulse_stretcher.sv
// Turns single-cycle tick requests into fixed-width pulses with a guaranteed low gap.
// Ticks that arrive during a pulse or its gap are queued in a saturating counter and replayed in order.
module tick_pulse_stretcher #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int PEND_W       = 3
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_TICK,
  input  logic              i_CLR_OVF,
  output logic              o_PULSE,
  output logic              o_BUSY,
  output logic [PEND_W-1:0] o_PEND_CNT,
  output logic              o_OVF
);

  localparam int MAX_C = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(MAX_C) + 1;

  localparam logic [TW-1:0]     PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]     T_ONE      = 1;
  localparam logic [PEND_W-1:0] P_ONE      = 1;
  localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  logic [TW-1:0]     r_timer;
  logic [PEND_W-1:0] r_pend;
  logic              r_pulse;
  logic              r_ovf;

  logic w_pend_nz;
  logic w_timer_z;
  logic w_can_start;
  logic w_start;
  logic w_dec;
  logic w_inc;
  logic w_drop;

  assign w_pend_nz   = (r_pend != '0);
  assign w_timer_z   = (r_timer == '0);
  assign w_can_start = (r_state == ST_IDLE) || ((r_state == ST_GAP) && w_timer_z);
  assign w_start     = w_can_start && (i_TICK || w_pend_nz);
  assign w_dec       = w_start && w_pend_nz;
  // A tick that launches a pulse straight from an empty queue bypasses the counter.
  assign w_inc       = i_TICK && !(w_start && !w_pend_nz);
  assign w_drop      = w_inc && !w_dec && (r_pend == PEND_MAX);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_pend  <= '0;
      r_pulse <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_inc && !w_dec && !w_drop) begin
        r_pend <= r_pend + P_ONE;
      end else if (w_dec && !w_inc) begin
        r_pend <= r_pend - P_ONE;
      end

      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_CLR_OVF) begin
        r_ovf <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_HIGH;
            r_pulse <= 1'b1;
            r_timer <= PULSE_LOAD;
          end
        end
        ST_HIGH: begin
          if (w_timer_z) begin
            r_state <= ST_GAP;
            r_pulse <= 1'b0;
            r_timer <= GAP_LOAD;
          end else begin
            r_timer <= r_timer - T_ONE;
          end
        end
        ST_GAP: begin
          if (!w_timer_z) begin
            r_timer <= r_timer - T_ONE;
          end else if (w_start) begin
            r_state <= ST_HIGH;
            r_pulse <= 1'b1;
            r_timer <= PULSE_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_pulse <= 1'b0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign o_PULSE    = r_pulse;
  assign o_PEND_CNT = r_pend;
  assign o_OVF      = r_ovf;
  assign o_BUSY     = (r_state != ST_IDLE) || w_pend_nz;

endmodule

// File: tb/tb_tick_pulse_stretcher.sv
// Directed bench for tick_pulse_stretcher: expected pulse start edges are queued by the
// stimulus and a monitor matches every observed pulse against them.
module tb_tick_pulse_stretcher;

  localparam int W      = 32;
  localparam int PEND_W = 2;
  localparam int PULSE  = 4;

  logic              i_CLK = 1'b0;
  logic              i_RST;
  logic              i_TICK;
  logic              i_CLR_OVF;
  logic              o_PULSE;
  logic              o_BUSY;
  logic [PEND_W-1:0] o_PEND_CNT;
  logic              o_OVF;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int e;

  logic [W-1:0] exp_q[$];

  tick_pulse_stretcher #(
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (4),
    .PEND_W      (PEND_W)
  ) dut (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .i_TICK    (i_TICK),
    .i_CLR_OVF (i_CLR_OVF),
    .o_PULSE   (o_PULSE),
    .o_BUSY    (o_BUSY),
    .o_PEND_CNT(o_PEND_CNT),
    .o_OVF     (o_OVF)
  );

  // clock / reset block
  always #5 i_CLK = ~i_CLK;
  always @(posedge i_CLK) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual time=%0t required=done", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // driver tasks (called on a falling edge)
  task automatic tick_run(input int n);
    i_TICK = 1'b1;
    repeat (n) @(negedge i_CLK);
    i_TICK = 1'b0;
  endtask

  task automatic wait_edge(input int t);
    while (cyc < t) @(negedge i_CLK);
  endtask

  // scoreboard monitor: every rising pulse pops one expected start edge
  logic in_pulse = 1'b0;
  int   width    = 0;
  initial forever begin
    @(negedge i_CLK);
    if (i_RST) begin
      in_pulse = 1'b0;
      width    = 0;
    end else if (o_PULSE && !in_pulse) begin
      in_pulse = 1'b1;
      width    = 1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pulse_unexpected at edge %0d: actual=1 pulse required=0 pulses", cyc);
      end else begin
        check("pulse_start", cyc, exp_q.pop_front());
      end
    end else if (o_PULSE) begin
      width++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      check("pulse_width", width, PULSE);
    end
  end

  initial begin
    i_RST     = 1'b1;
    i_TICK    = 1'b0;
    i_CLR_OVF = 1'b0;
    #1;
    check("rst_pulse", o_PULSE, 0);
    check("rst_busy", o_BUSY, 0);
    check("rst_pend", o_PEND_CNT, 0);
    check("rst_ovf", o_OVF, 0);
    repeat (3) @(negedge i_CLK);
    i_RST = 1'b0;

    // single tick
    wait_edge(9);
    e = cyc + 1;
    exp_q.push_back(e);
    tick_run(1);
    check("t1_pend", o_PEND_CNT, 0);
    wait_edge(e + 7);
    check("t1_busy_gap_end", o_BUSY, 1);
    wait_edge(e + 8);
    check("t1_busy_idle", o_BUSY, 0);
    check("t1_ovf", o_OVF, 0);

    // three consecutive ticks
    wait_edge(e + 20);
    e = cyc + 1;
    exp_q.push_back(e);
    exp_q.push_back(e + 8);
    exp_q.push_back(e + 16);
    tick_run(3);
    check("t2_pend_peak", o_PEND_CNT, 2);
    wait_edge(e + 15);
    check("t2_pend_before3", o_PEND_CNT, 1);
    wait_edge(e + 16);
    check("t2_pend_after3", o_PEND_CNT, 0);
    wait_edge(e + 23);
    check("t2_busy_last", o_BUSY, 1);
    wait_edge(e + 24);
    check("t2_busy_low", o_BUSY, 0);

    // saturation: 6 ticks, then tick+clear together
    wait_edge(e + 30);
    e = cyc + 1;
    exp_q.push_back(e);
    exp_q.push_back(e + 8);
    exp_q.push_back(e + 16);
    exp_q.push_back(e + 24);
    tick_run(4);
    check("t3_pend_full", o_PEND_CNT, 3);
    check("t3_ovf_before", o_OVF, 0);
    tick_run(2);
    check("t3_ovf_set", o_OVF, 1);
    check("t3_pend_hold", o_PEND_CNT, 3);
    i_TICK    = 1'b1;
    i_CLR_OVF = 1'b1;
    @(negedge i_CLK);
    i_TICK    = 1'b0;
    i_CLR_OVF = 1'b0;
    check("t3_set_wins", o_OVF, 1);
    check("t3_pend_sat", o_PEND_CNT, 3);
    wait_edge(e + 8);
    check("t3_pend_dec", o_PEND_CNT, 2);
    wait_edge(e + 40);
    check("t3_ovf_sticky", o_OVF, 1);
    check("t3_pend_empty", o_PEND_CNT, 0);
    check("t3_busy_low", o_BUSY, 0);
    i_CLR_OVF = 1'b1;
    @(negedge i_CLK);
    i_CLR_OVF = 1'b0;
    check("t3_ovf_clr", o_OVF, 0);

    // tick on the last gap cycle restarts without an idle cycle
    wait_edge(cyc + 3);
    e = cyc + 1;
    exp_q.push_back(e);
    exp_q.push_back(e + 8);
    tick_run(1);
    wait_edge(e + 7);
    tick_run(1);
    check("t4_pend", o_PEND_CNT, 0);
    check("t4_busy", o_BUSY, 1);
    check("t4_pulse", o_PULSE, 1);
    wait_edge(e + 24);
    check("t4_busy_low", o_BUSY, 0);

    // asynchronous reset during a pulse with a full queue
    wait_edge(cyc + 3);
    e = cyc + 1;
    exp_q.push_back(e);
    tick_run(4);
    check("t5_pend_full", o_PEND_CNT, 3);
    check("t5_pulse_high", o_PULSE, 1);
    #2 i_RST = 1'b1;
    #1;
    check("t5_rst_pulse", o_PULSE, 0);
    check("t5_rst_pend", o_PEND_CNT, 0);
    check("t5_rst_ovf", o_OVF, 0);
    check("t5_rst_busy", o_BUSY, 0);
    repeat (2) @(negedge i_CLK);
    i_RST = 1'b0;
    repeat (30) @(negedge i_CLK);
    check("t5_post_busy", o_BUSY, 0);
    check("t5_post_pend", o_PEND_CNT, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_pulse_stretcher.md
Name: tick_pulse_stretcher

Overview:
- Converts single-cycle tick requests into clean, fixed-width level pulses with guaranteed minimum low time between them. This is the inverse of the button edge-to-tick path.
- Typical use: replaying or queuing press events towards the OLED command sequencer, and driving LEDs or test pins that need visible, debounced-looking strobes.
- Ticks arriving while a pulse is in progress are counted in a saturating pending counter and replayed in order.
- Overflow is flagged sticky.

Parameters:
- PULSE_CYCLES, 4, number of clock cycles o_PULSE is held high per event (must be >= 1).
- GAP_CYCLES, 4, minimum number of clock cycles o_PULSE is held low after each pulse (must be >= 1).
- PEND_W, 3, width of the pending-event counter; maximum queued events = 2^PEND_W - 1.

Ports:
- i_CLK  input  1  system clock; all state updates on the rising edge.
- i_RST  input  1  reset, asynchronous, active-high.
- i_TICK  input  1  one-cycle event request; every cycle it is high counts as one event.
- i_CLR_OVF  input  1  synchronous clear of o_OVF.
- o_PULSE  output  1  stretched pulse, registered.
- o_BUSY  output  1  high while state != IDLE or pending count != 0.
- o_PEND_CNT  output  PEND_W  current number of queued, not-yet-started events.
- o_OVF  output  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset (async, any time, including mid-pulse): state=IDLE, timer=0, o_PULSE=0, o_PEND_CNT=0, o_OVF=0. Outputs drop immediately when reset asserts. No event survives reset.
- Timer width: $clog2(max(PULSE_CYCLES, GAP_CYCLES)) + 1 bits; unsigned down-count.
- FSM states: IDLE, HIGH, GAP.
- IDLE:
  - If i_TICK=1 or pend>0 at a rising edge: go to HIGH, o_PULSE<=1, timer<=PULSE_CYCLES-1.
  - If starting from a tick with pend=0, the tick is consumed directly and pend is unchanged.
  - If pend>0, pend decrements. A simultaneous tick increments pend, so the net change is 0.
- HIGH: if timer==0, go to GAP, o_PULSE<=0, timer<=GAP_CYCLES-1; else timer decrements.
- GAP:
  - If timer!=0: timer decrements.
  - If timer==0 and (pend>0 or i_TICK): go to HIGH directly, o_PULSE<=1, timer reload, one event consumed by the same rules as IDLE.
  - If timer==0 and no pend and no tick: go to IDLE.
- Latency: tick sampled at edge k from IDLE with pend=0 means o_PULSE is high from edge k to edge k+PULSE_CYCLES, exactly PULSE_CYCLES cycles.
- Event period: back-to-back queued events yield a period of PULSE_CYCLES+GAP_CYCLES cycles.
- Pending counter, ticks not consumed on the same edge:
  - A tick while in HIGH, or in GAP with timer!=0, increments pend.
  - Increment and decrement on the same edge: net 0.
  - Saturation: when pend==2^PEND_W-1 and a tick would increment without a concurrent decrement, pend holds, the tick is dropped, and o_OVF<=1.
- o_OVF clear: i_CLR_OVF clears o_OVF on the next edge. If a set and a clear occur on the same edge, the set wins.
- o_BUSY: combinational from registered state. It goes low only in IDLE with pend==0.
- Ordering guarantee: the number of pulses emitted equals the number of accepted ticks. Ticks dropped at saturation are never emitted.

Test Plan:
- Single tick at cycle 10, default params -> o_PULSE high cycles 11-14, low after; o_BUSY high 11-18; pend stays 0; o_OVF=0.
- Three ticks on consecutive cycles 10,11,12 -> pend peaks at 2; pulses start at cycles 11, 19, 27, each 4 cycles; pend reaches 0 after the third pulse starts; o_BUSY low from cycle 35.
- PEND_W=2, 6 ticks back-to-back from IDLE -> 1 consumed plus 3 queued; ticks 5 and 6 dropped; o_OVF=1; exactly 4 pulses emitted; o_OVF stays 1 until i_CLR_OVF, then 0 on the next edge.
- Tick landing on the last GAP cycle (timer==0) with pend=0 -> o_PULSE rises on the next edge with no IDLE cycle; pend unchanged.
- i_RST asserted asynchronously mid-HIGH with pend=3 -> o_PULSE, o_PEND_CNT, o_OVF and o_BUSY go to 0 immediately; no pulses after release until a new tick.
- Saturated pend with i_TICK and i_CLR_OVF asserted on the same edge -> o_OVF remains 1; in a separate run, i_CLR_OVF alone -> o_OVF becomes 0.
